// File: rtl/or_and_loader_if.sv
// or_and_loader_if: pair stream, tree operand/result wires and result stream of or_and_loader.
interface or_and_loader_if #(parameter int N = 8);
  logic flush, in_valid, in_ready, in_x, in_y, Z, res_valid, res_ready, res_z;
  logic [N-1:0] X, Y;
  modport master (output flush, in_valid, in_x, in_y, Z, res_ready, input in_ready, X, Y, res_valid, res_z);
  modport slave (input flush, in_valid, in_x, in_y, Z, res_ready, output in_ready, X, Y, res_valid, res_z);
endinterface

// File: rtl/or_and_loader.sv
// or_and_loader: packs N serial (x,y) pairs into registered X/Y for or_and_tree and returns its Z on a result stream.
// Defining OAT_STATS_EN adds ones_cnt, a saturating count of results captured with res_z=1.
module or_and_loader #(parameter int N = 8) (
  input logic clk,
  input logic rst_n,
  or_and_loader_if.slave bus
`ifdef OAT_STATS_EN
  , output logic [15:0] ones_cnt
`endif
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {FILL, EVAL, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0] x_q, y_q;
  logic res_z_q, take, last;
  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("or_and_loader: N must be a power of 2 and >= 2");
  end
  assign take = bus.in_valid && state == FILL && !bus.flush;
  assign last = cnt == CW'(N - 1);
  assign bus.X = x_q;
  assign bus.Y = y_q;
  assign bus.res_z = res_z_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nx;
  always_comb
    state_nx = bus.flush ? FILL :
               state == FILL ? ((take && last) ? EVAL : FILL) :
               state == EVAL ? HOLD :
               bus.res_ready ? FILL : HOLD;
  always_comb begin
    bus.in_ready = state == FILL;
    bus.res_valid = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      x_q <= '0;
      y_q <= '0;
      res_z_q <= 1'b0;
    end else if (bus.flush) begin
      cnt <= '0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (take) begin
        x_q[cnt] <= bus.in_x;
        y_q[cnt] <= bus.in_y;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (state == EVAL) res_z_q <= bus.Z;
    end
`ifdef OAT_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ones_cnt <= '0;
    else if (state == EVAL && !bus.flush && bus.Z && ones_cnt != 16'hFFFF) ones_cnt <= ones_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_or_and_loader.sv
// tb_or_and_loader: directed and random frames checked cycle by cycle against a frame-level reference model.
module tb_or_and_loader;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int passed = 0, total = 0, failed = 0;
  string phase = "init";
  logic [N-1:0] m_x = '0, m_y = '0;
  logic m_z = 1'b0, nb;
  bit m_eval = 0, m_hold = 0;
  int m_k = 0, m_ones = 0;
`ifdef OAT_STATS_EN
  logic [15:0] ones_cnt;
`endif
  or_and_loader_if #(.N(N)) bus();
  or_and_loader #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef OAT_STATS_EN
    , .ones_cnt(ones_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic tree(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] v;
    int w, k;
    v = x & y;
    w = N;
    k = 1;
    while (w > 1) begin
      for (int i = 0; i < w / 2; i++) v[i] = (k % 2 == 1) ? (v[2*i] | v[2*i+1]) : (v[2*i] & v[2*i+1]);
      w = w / 2;
      k++;
    end
    return v[0];
  endfunction
  assign bus.Z = tree(bus.X, bus.Y);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask
  task automatic tick();
    if (bus.flush) begin
      m_k = 0; m_x = '0; m_y = '0; m_eval = 0; m_hold = 0;
    end else if (m_eval) begin
      m_z = tree(m_x, m_y); m_eval = 0; m_hold = 1;
      if (m_z && m_ones < 65535) m_ones++;
    end else if (m_hold) begin
      if (bus.res_ready) m_hold = 0;
    end else if (bus.in_valid) begin
      m_x[m_k] = bus.in_x; m_y[m_k] = bus.in_y; m_k++;
      if (m_k == N) begin m_k = 0; m_eval = 1; end
    end
    @(posedge clk); #1;
    chk("cycle", {bus.in_ready, bus.res_valid, bus.res_z, bus.X, bus.Y}, {!(m_eval || m_hold), m_hold, m_z, m_x, m_y});
`ifdef OAT_STATS_EN
    chk("ones_cnt", 32'(ones_cnt), 32'(m_ones));
`endif
  endtask
  task automatic pair(input logic x, input logic y);
    bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y;
    tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_rst", {bus.res_valid, bus.res_z, bus.X, bus.Y}, 0);
    m_k = 0; m_x = '0; m_y = '0; m_z = 1'b0; m_eval = 0; m_hold = 0; m_ones = 0;
`ifdef OAT_STATS_EN
    chk("rst_ones", 32'(ones_cnt), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_x = 1'b1; bus.in_y = 1'b1; bus.res_ready = 1'b0;
    #2;
    phase = "t1";
    do_reset();
    chk("rel_inready", bus.in_ready, 1);
    pair(1'b1, 1'b0);
    chk("first_bit0", {bus.X, bus.Y}, {8'h01, 8'h00});
    bus.res_ready = 1'b1;
    for (int i = 1; i < N; i++) pair(1'b1, 1'b1);
    tick(); tick();
    phase = "t2";
    for (int i = 0; i < N; i++) pair(1'b1, 1'b1);
    chk("xy_ff", {bus.X, bus.Y}, {8'hFF, 8'hFF});
    tick();
    chk("res", {bus.res_valid, bus.res_z}, 2'b11);
    tick();
    chk("pulse", bus.res_valid, 0);
    phase = "t3";
    for (int i = 0; i < N; i++) pair(i < 4, i < 4);
    tick();
    chk("z_lo4", bus.res_z, 1);
    tick();
    for (int i = 0; i < N; i++) pair(i == 0, i == 0);
    tick();
    chk("z_bit0", bus.res_z, 0);
    tick();
    phase = "t4";
    for (int i = 0; i < N; i++) pair(1'($urandom), 1'($urandom));
    bus.res_ready = 1'b0;
    tick();
    repeat (5) pair(1'($urandom), 1'($urandom));
    chk("hold_inready", bus.in_ready, 0);
    bus.res_ready = 1'b1;
    tick();
    nb = !m_x[0];
    pair(nb, nb);
    chk("next_bit0", {bus.X[0], bus.Y[0]}, {nb, nb});
    phase = "t5";
    for (int i = 1; i < N; i++) pair(1'($urandom), 1'($urandom));
    tick(); tick();
    repeat (3) pair(1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_xy", {bus.X, bus.Y}, 0);
    for (int i = 0; i < N; i++) pair(1'($urandom), 1'($urandom));
    tick(); tick();
    bus.res_ready = 1'b0;
    for (int i = 0; i < N; i++) pair(1'b1, 1'b1);
    tick(); tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("hold_flush", {bus.res_valid, bus.res_z}, 2'b01);
    bus.res_ready = 1'b1;
    phase = "t6";
    repeat (5) pair(1'b1, 1'b1);
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) pair(f < 3, 1'b1);
      tick(); tick();
    end
`ifdef OAT_STATS_EN
    chk("ones3", 32'(ones_cnt), 3);
`endif
    bus.res_ready = 1'b0;
    for (int i = 0; i < N; i++) pair(1'b1, 1'b1);
    tick(); tick();
    do_reset();
    phase = "rand";
    repeat (400) begin
      bus.flush = $urandom_range(0, 19) == 0;
      bus.in_valid = 1'($urandom);
      bus.in_x = $urandom_range(0, 3) != 0;
      bus.in_y = $urandom_range(0, 3) != 0;
      bus.res_ready = 1'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
